// File: rtl/period_meter_if.sv
// Result handshake between period_meter and its consumer.
interface period_meter_if #(parameter int N = 32);
  logic [N-1:0] m_match;
  logic         m_rise;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_match, m_rise, m_valid, input m_ready);
  modport slave  (input m_match, m_rise, m_valid, output m_ready);
endinterface

// File: rtl/period_meter.sv
// Measures half-periods of a toggling input in clk cycles, reported as the
// timer match value (H-1) over a valid/ready result port.
module period_meter #(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          signal_in,
  period_meter_if.master m,
  output logic          overrun,
  output logic          locked,
  output logic          stalled
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic [N-1:0]           match_q, match_d;
  logic                   rise_q, rise_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   locked_q, locked_d;
  logic                   stalled_q, stalled_d;

  logic sync_out, strobe, rise_edge, cnt_max, new_res, xfer;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], signal_in};
    sync_out  = sync_q[SYNC_STAGES-1];
    prev_d    = sync_out;
    strobe    = sync_out ^ prev_q;
    rise_edge = sync_out & ~prev_q;
    cnt_max   = &cnt_q;

    if (strobe)       cnt_d = '0;
    else if (cnt_max) cnt_d = cnt_q;
    else              cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};

    state_d   = state_q;
    stalled_d = stalled_q;
    new_res   = 1'b0;
    case (state_q)
      IDLE: begin
        // first edge only arms: it has no earlier edge to measure against
        if (strobe) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
        end
      end
      MEASURE: begin
        if (strobe) begin
          new_res = 1'b1;
        end else if (cnt_max) begin
          state_d   = IDLE;
          stalled_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == MEASURE);

    xfer    = valid_q & m.m_ready;
    match_d = new_res ? cnt_q     : match_q;
    rise_d  = new_res ? rise_edge : rise_q;
    valid_d = new_res | (valid_q & ~m.m_ready);

    // a result landing in an accept cycle replaces cleanly and leaves overrun alone
    overrun_d = overrun_q;
    if (new_res && valid_q && !m.m_ready) overrun_d = 1'b1;
    else if (xfer && !new_res)            overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      match_q   <= '0;
      rise_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      locked_q  <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      rise_q    <= rise_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      locked_q  <= locked_d;
      stalled_q <= stalled_d;
    end
  end

  assign m.m_match = match_q;
  assign m.m_rise  = rise_q;
  assign m.m_valid = valid_q;
  assign overrun   = overrun_q;
  assign locked    = locked_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: N=8 instance with a result scoreboard, N=4 instance for timeout.
module tb_period_meter;

  logic clk, rst;
  logic sig8, sig4;
  logic ov8, lk8, st8, ov4, lk4, st4;

  period_meter_if #(.N(8)) if8 ();
  period_meter_if #(.N(4)) if4 ();

  period_meter #(.N(8), .SYNC_STAGES(2)) u8 (
    .clk(clk), .rst(rst), .signal_in(sig8), .m(if8),
    .overrun(ov8), .locked(lk8), .stalled(st8)
  );

  period_meter #(.N(4), .SYNC_STAGES(2)) u4 (
    .clk(clk), .rst(rst), .signal_in(sig4), .m(if4),
    .overrun(ov4), .locked(lk4), .stalled(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m;
    logic       r;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_tog = 0;
  bit   armed  = 0;
  bit   sb_en  = 0;
  bit   cont_en = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // one clk cycle; a transfer seen here completes on the coming rising edge
  task automatic tick();
    exp_t e;
    #1;
    if (sb_en && if8.m_valid && if8.m_ready) begin
      if (q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_match", {24'd0, if8.m_match}, {24'd0, e.m});
        chk("sb_rise", {31'd0, if8.m_rise}, {31'd0, e.r});
      end
    end
    if (cont_en) chk("cont_valid", {31'd0, if8.m_valid}, 1);
    @(negedge clk);
    cyc++;
  endtask

  // wait h cycles, toggle the N=8 input, expect (interval-1) once armed
  task automatic tog(input int h);
    exp_t e;
    repeat (h) tick();
    sig8 = ~sig8;
    if (armed && sb_en) begin
      e.m = 8'(cyc - last_tog - 1);
      e.r = sig8;
      q.push_back(e);
    end
    armed    = 1;
    last_tog = cyc;
  endtask

  initial begin
    bit bad;
    rst = 1'b1; sig8 = 1'b0; sig4 = 1'b0;
    if8.m_ready = 1'b1; if4.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_match", {24'd0, if8.m_match}, 0);
    chk("rst_rise", {31'd0, if8.m_rise}, 0);
    chk("rst_valid", {31'd0, if8.m_valid}, 0);
    chk("rst_overrun", {31'd0, ov8}, 0);
    chk("rst_locked", {31'd0, lk8}, 0);
    chk("rst_stalled", {31'd0, st8}, 0);
    rst = 1'b0;

    // timeout, re-arm and H=2^N on the N=4 instance
    bad = 0;
    for (int c = 0; c <= 52; c++) begin
      if (c < 35) bad = bad | if4.m_valid;
      case (c)
        0:  sig4 = 1'b1;
        2:  chk("t4_lock_pre", {31'd0, lk4}, 0);
        3:  chk("t4_lock_arm", {31'd0, lk4}, 1);
        18: begin chk("t4_stall_pre", {31'd0, st4}, 0); chk("t4_lock_pre_to", {31'd0, lk4}, 1); end
        19: begin chk("t4_stall", {31'd0, st4}, 1); chk("t4_lock_to", {31'd0, lk4}, 0); end
        25: sig4 = 1'b0;
        27: chk("t4_stall_hold", {31'd0, st4}, 1);
        28: begin chk("t4_stall_clr", {31'd0, st4}, 0); chk("t4_relock", {31'd0, lk4}, 1); end
        32: sig4 = 1'b1;
        35: begin
          chk("t4_no_result", {31'd0, bad}, 0);
          chk("t4_valid", {31'd0, if4.m_valid}, 1);
          chk("t4_match6", {28'd0, if4.m_match}, 6);
          chk("t4_rise", {31'd0, if4.m_rise}, 1);
        end
        36: chk("t4_valid_drop", {31'd0, if4.m_valid}, 0);
        48: sig4 = 1'b0;
        51: begin
          chk("t4_max_valid", {31'd0, if4.m_valid}, 1);
          chk("t4_max_match", {28'd0, if4.m_match}, 15);
          chk("t4_max_rise", {31'd0, if4.m_rise}, 0);
          chk("t4_max_nostall", {31'd0, st4}, 0);
          chk("t4_max_lock", {31'd0, lk4}, 1);
        end
        default: ;
      endcase
      tick();
    end

    // steady wave, half-period 5, no backpressure
    sb_en = 1; armed = 0;
    repeat (8) tog(5);
    chk("t1_locked", {31'd0, lk8}, 1);
    chk("t1_overrun", {31'd0, ov8}, 0);

    // minimum interval: toggling every cycle
    for (int i = 0; i < 20; i++) begin
      if (i == 5) cont_en = 1;
      tog(1);
    end
    cont_en = 0;

    // backpressure with half-period 3
    repeat (3) tick();
    sig8 = ~sig8;
    tick();
    chk("t3_sb_drained", q.size(), 0);
    sb_en = 0;
    for (int c = 4; c <= 16; c++) begin
      case (c)
        4:  if8.m_ready = 1'b0;
        6:  begin
          chk("t3_first_valid", {31'd0, if8.m_valid}, 1);
          chk("t3_first_match", {24'd0, if8.m_match}, 2);
          chk("t3_first_noov", {31'd0, ov8}, 0);
        end
        9:  begin
          chk("t3_second_ov", {31'd0, ov8}, 1);
          chk("t3_second_match", {24'd0, if8.m_match}, 2);
        end
        12: begin
          chk("t3_hold_valid", {31'd0, if8.m_valid}, 1);
          chk("t3_hold_match", {24'd0, if8.m_match}, 2);
        end
        13: if8.m_ready = 1'b1;
        14: begin
          chk("t3_xfer_drop", {31'd0, if8.m_valid}, 0);
          chk("t3_xfer_ovclr", {31'd0, ov8}, 0);
        end
        15: begin
          chk("t3_next_valid", {31'd0, if8.m_valid}, 1);
          chk("t3_next_match", {24'd0, if8.m_match}, 2);
          chk("t3_next_noov", {31'd0, ov8}, 0);
        end
        16: chk("t3_final_drop", {31'd0, if8.m_valid}, 0);
        default: ;
      endcase
      if (c == 6 || c == 9 || c == 12) sig8 = ~sig8;
      tick();
    end

    // clean reset, rerun the steady wave, then reset with a result pending
    sig8 = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; armed = 0; q.delete(); sb_en = 1;
    repeat (7) tog(5);
    repeat (3) tick();
    chk("t5_pre_valid", {31'd0, if8.m_valid}, 1);
    chk("t5_pre_sig", {31'd0, sig8}, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_match", {24'd0, if8.m_match}, 0);
    chk("t5_rst_rise", {31'd0, if8.m_rise}, 0);
    chk("t5_rst_valid", {31'd0, if8.m_valid}, 0);
    chk("t5_rst_overrun", {31'd0, ov8}, 0);
    chk("t5_rst_locked", {31'd0, lk8}, 0);
    chk("t5_rst_stalled", {31'd0, st8}, 0);
    q.delete();
    tick();
    rst = 1'b0;
    // held-high input at release acts as the arming edge
    armed = 1; last_tog = cyc;
    repeat (2) tog(5);
    repeat (4) tick();
    chk("t5_sb_drained", q.size(), 0);

    // accept on exactly the cycle a new result loads
    if8.m_ready = 1'b0;
    tog(6);
    tog(4);
    repeat (2) tick();
    chk("t6_held_valid", {31'd0, if8.m_valid}, 1);
    if8.m_ready = 1'b1;
    tick();
    if8.m_ready = 1'b0;
    chk("t6_new_valid", {31'd0, if8.m_valid}, 1);
    chk("t6_new_match", {24'd0, if8.m_match}, 3);
    chk("t6_noov", {31'd0, ov8}, 0);
    if8.m_ready = 1'b1;
    repeat (4) tick();
    chk("sb_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the interval between successive transitions of a toggling input (both edges) in clock cycles. Each result is reported as the match value that would make `timer` regenerate the same waveform: a half-period of H cycles gives match = H − 1. The block sits on the analysis/feedback path of the synth and receives external or looped-back square waves. It does pitch detection, and lets a timer be locked to the incoming rate.

## Interface

Parameters:
- `N`, 32: measurement width; also the saturation/timeout limit (2^N − 1).
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer, ≥ 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `signal_in`  in  1  toggling input, asynchronous to `clk`.
- `m_match`  out  N  measured half-period minus one.
- `m_rise`  out  1  1 = interval ended on a rising edge (low phase measured); 0 = ended on a falling edge (high phase).
- `m_valid`  out  1  result available.
- `m_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky: an unaccepted result was overwritten.
- `locked`  out  1  state is MEASURE.
- `stalled`  out  1  sticky: timeout occurred since the last edge.

## Operation

- **Synchronizer.** `signal_in` passes through `SYNC_STAGES` flops, then a previous-value register. `strobe` = sync_out XOR prev. `rise` = sync_out & ~prev.
- **Counter `cnt`** (N bits):
  - cleared to 0 on every `strobe`;
  - otherwise increments, saturating at all-ones.
  - Result: a strobe H cycles after the previous strobe sees `cnt` = H − 1.
- **FSM states: IDLE, MEASURE.**
  - **IDLE:**
    - On `strobe`: go to MEASURE, clear `cnt`, clear `stalled`.
    - No result is produced, because the first edge has no reference.
  - **MEASURE:**
    - On `strobe`: load `m_match` ← `cnt` and `m_rise` ← `rise`, set `m_valid`, clear `cnt`, stay in MEASURE.
    - When `cnt` = all-ones and no `strobe`: go to IDLE, set `stalled`, no result.
    - Strobe on the saturation cycle: the strobe wins, producing result all-ones, staying in MEASURE, with no stall.
- **Output handshake (valid/ready):**
  - Transfer happens when `m_valid` & `m_ready`.
  - `m_match` and `m_rise` are stable while `m_valid` is high and no transfer occurs.
  - Transfer with no new result: `m_valid` falls the next cycle.
  - Transfer and new result in the same cycle: the new result is loaded, `m_valid` stays high, `overrun` is unchanged.
  - New result while `m_valid` & ~`m_ready`: the new result overwrites and `overrun` is set.
  - `overrun` clears on the next transfer cycle. If a new overwrite happens in that same cycle, set wins.
- **Reset values:**
  - FSM = IDLE.
  - All outputs are 0: `m_match` = 0, `m_rise` = 0, `m_valid` = 0, `overrun` = 0, `locked` = 0, `stalled` = 0.
  - Synchronizer flops, prev register and `cnt` are 0.
- **Reset asserted mid-operation:** everything clears immediately and any pending result is lost. If `signal_in` is high at release, the resulting rising strobe is only the arming edge in IDLE; no spurious result is produced.

## Timing

- Input transition to `strobe`: `SYNC_STAGES` + 1 clk cycles (±1 from sampling uncertainty).
- `strobe` to `m_valid` high: 1 cycle (registered).
- Measured intervals are exact in clk cycles for a synchronous input; for an asynchronous input, ±1 per interval.
- Minimum interval: H = 1 (input toggling every clk cycle). Every cycle strobes, and every result is `m_match` = 0.
- Maximum reportable: H = 2^N, giving `m_match` = all-ones. Once `cnt` has held all-ones for one cycle without a strobe (no edge in 2^N cycles since the last strobe), the FSM goes to IDLE and sets `stalled`.
- `locked` is registered from the state; it rises 1 cycle after the arming strobe.

## Test plan

1. **Steady wave, no backpressure.** Drive `signal_in` synchronously with half-period 5 (a `timer` with match 4), `m_ready` = 1. Required: first edge produces no result; then `m_match` = 4 every 5 cycles, `m_rise` alternating, `overrun` = 0, `locked` = 1.
2. **Minimum interval.** Toggle the input every cycle, N = 8. Required: `m_valid` stays high continuously, `m_match` = 0, `m_rise` alternating 1/0.
3. **Backpressure.** Half-period 3, `m_ready` = 0 for 10 cycles, then 1. Required:
   - `m_match` = 2 held while blocked;
   - `overrun` sets at the second result;
   - on the first transfer, `overrun` clears and `m_valid` drops only when no same-cycle result is pending.
4. **Timeout.** N = 4, one edge, then no edges.
   - Required: `stalled` = 1 and `locked` = 0 once `cnt` has held 15 for one cycle without a strobe (16 cycles after the arming strobe), with no result produced.
   - The next edge clears `stalled` and produces no result. The edge after that produces a correct result.
   - Edge at exactly H = 16 (strobe on the cycle `cnt` first reaches 15): required result `m_match` = 15, no stall.
5. **Reset mid-measure.** Run scenario 1, then assert `rst` for 1 cycle with `m_valid` high and the input held high. Required:
   - all outputs 0 immediately;
   - after release, the first edge only arms;
   - the first result after re-arming is correct (4).
6. **Simultaneous accept and new result.** `m_ready` = 1 exactly on the cycle a new result loads. Required: new value presented, `m_valid` continuous, `overrun` = 0.
